crypt_stream_ctrl: RTL and testbench
====================================

Name: crypt_stream_ctrl

Overview:
Sequencer that shares one encrypter/decrypter datapath pair between a byte stream and a key register. It accepts bytes over a valid/ready handshake and drives the datapath message/key inputs. It captures the selected result (encrypt or decrypt) into an output register and presents it over a valid/ready handshake. It holds the session key, optionally rolling it after every byte, and counts processed bytes.

Parameters:
DATA_W, 8, width of message, key and result
ROT, 1, left-rotate amount applied to the working key per byte when roll_en=1 (0..DATA_W-1)
CNT_W, 16, width of processed-byte counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
key_load  in  1  load key_in as session key (pulse)
key_in  in  DATA_W  session key value
key_clear  in  1  discard session key, return to no-key state
mode  in  1  0=encrypt, 1=decrypt; sampled with each accepted byte
roll_en  in  1  enable per-byte key rotation; sampled with each accepted byte
in_valid  in  1  input byte valid
in_ready  out  1  controller can accept a byte
in_data  in  DATA_W  input byte
dp_message  out  DATA_W  to datapath message inputs (both encrypter and decrypter)
dp_key  out  DATA_W  to datapath key inputs
enc_result  in  DATA_W  encrypter output (combinational)
dec_result  in  DATA_W  decrypter output (combinational)
out_valid  out  1  result byte valid
out_ready  in  1  downstream accepts result
out_data  out  DATA_W  result byte
key_valid  out  1  session key loaded
key_err  out  1  one-cycle pulse: key_load/key_clear rejected
byte_count  out  CNT_W  bytes delivered since key load

Behaviour:
- Reset: state NOKEY; all outputs 0 (in_ready, out_valid, out_data, dp_message, dp_key, key_valid, key_err, byte_count); the key register, working key and mode latch are cleared.
- States: NOKEY, IDLE, PROC, HOLD.
- NOKEY: in_ready=0. key_load -> latch key_in as session key and working key; byte_count<=0; -> IDLE.
- IDLE: in_ready=1, key_valid=1.
  - in_valid&in_ready -> latch in_data into dp_message, latch mode and roll_en; -> PROC.
  - key_load (no handshake this cycle) -> reload session/working key, byte_count<=0, stay IDLE.
  - key_clear -> NOKEY.
  - key_load together with in_valid: the byte is taken with the old key; the key_load is rejected with a key_err pulse.
- PROC: dp_message and dp_key are held stable for a full cycle. At the end of the cycle, out_data <= mode ? dec_result : enc_result and out_valid<=1; -> HOLD.
- HOLD: out_valid=1 and out_data are stable until out_ready. On out_ready:
  - out_valid<=0 and byte_count<=byte_count+1, wrapping modulo 2^CNT_W.
  - If the latched roll_en=1, the working key rotates left by ROT; otherwise it is unchanged.
  - -> IDLE.
- Latency: handshake in cycle N -> PROC in N+1 -> out_valid high in N+2. Maximum throughput is 1 byte per 3 cycles.
- dp_key always equals the working key; it changes only on key load or rotation, never during PROC/HOLD.
- key_load or key_clear during PROC/HOLD is ignored and key_err pulses for 1 cycle. In-flight bytes always complete with their original key.
- Rotation with ROT=0 is the identity. The session key register is only changed by key_load. key_clear in IDLE also clears the working key and the session key.
- out_valid never drops without out_ready. in_ready is 0 in all states except IDLE.
- reset mid-operation (PROC/HOLD) -> NOKEY next cycle with all reset values; the in-flight byte is dropped.

Decomposition:
- Shared package crypt_pkg: state encoding (NOKEY, IDLE, PROC, HOLD), default DATA_W and CNT_W, and the MODE_ENC/MODE_DEC constants.
- Sub-module key_roll: a combinational rotate-left-by-ROT of the working key. All other logic stays in one always block with separate next-state logic.

Test Plan:
- Reset then in_valid=1 -> in_ready=0, no out_valid and key_valid=0 for 10 cycles.
- key_load key_in=8'b01000011; byte 8'b01010101 with mode=0, roll_en=0:
  - dp_message=8'b01010101 and dp_key=8'b01000011 in PROC.
  - out_valid 2 cycles after the handshake with out_data=enc_result, and byte_count=1 after out_ready.
- Same key, mode=1, byte=the previous encrypted byte -> out_data=dec_result=8'b01010101 (round trip through the real encrypter/decrypter).
- roll_en=1, ROT=1, key 8'b01000011; send 3 bytes -> dp_key is 8'b01000011, 8'b10000110, 8'b00001101 for bytes 1, 2, 3.
- Hold out_ready=0 for 5 cycles in HOLD, with key_load pulsed:
  - out_data stable and in_ready=0 throughout.
  - key_err pulses once and dp_key is unchanged.
  - After out_ready the FSM returns to IDLE.
- Assert reset during PROC -> all outputs 0 next cycle and key_valid=0. Also preload byte_count to 16'hFFFF by sequence and deliver one more byte -> byte_count wraps to 0.

Source files
------------

// File: rtl/crypt_pkg.sv
// Shared definitions for the crypt stream controller: state encoding,
// default widths and the mode select constants.
package crypt_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_NOKEY = 2'd0,
        ST_IDLE  = 2'd1,
        ST_PROC  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/crypt_stream_ctrl_key_roll.sv
// Left-rotate of the working key by a fixed amount; ROT=0 passes the key through.
module key_roll #(
    parameter int DATA_W = 8,
    parameter int ROT    = 1
) (
    input  logic [DATA_W-1:0] key_cur,
    output logic [DATA_W-1:0] key_next
);

    // A shift by DATA_W yields zero, so ROT=0 collapses to the identity.
    assign key_next = (key_cur << ROT) | (key_cur >> (DATA_W - ROT));

endmodule

// File: rtl/crypt_stream_ctrl.sv
// Byte-stream sequencer sharing one encrypter/decrypter pair with a session key.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_NOKEY | no session key; input blocked, waiting for key_load
// ST_IDLE  | key present; ready for a byte, key reload or key clear
// ST_PROC  | datapath inputs held stable for one full cycle
// ST_HOLD  | result presented on out_data until out_ready
module crypt_stream_ctrl
    import crypt_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROT    = 1,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_load,
    input  logic [DATA_W-1:0] key_in,
    input  logic              key_clear,
    input  logic              mode,
    input  logic              roll_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] dp_message,
    output logic [DATA_W-1:0] dp_key,
    input  logic [DATA_W-1:0] enc_result,
    input  logic [DATA_W-1:0] dec_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              key_valid,
    output logic              key_err,
    output logic [CNT_W-1:0]  byte_count
);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  sess_key_q, sess_key_d;
    logic [DATA_W-1:0]  work_key_q, work_key_d;
    logic [DATA_W-1:0]  msg_q, msg_d;
    logic               mode_q, mode_d;
    logic               roll_q, roll_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               key_err_q, key_err_d;
    logic [DATA_W-1:0]  work_key_rot;

    key_roll #(
        .DATA_W (DATA_W),
        .ROT    (ROT)
    ) u_key_roll (
        .key_cur  (work_key_q),
        .key_next (work_key_rot)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_NOKEY;
            sess_key_q <= '0;
            work_key_q <= '0;
            msg_q      <= '0;
            mode_q     <= 1'b0;
            roll_q     <= 1'b0;
            out_data_q <= '0;
            cnt_q      <= '0;
            key_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sess_key_q <= sess_key_d;
            work_key_q <= work_key_d;
            msg_q      <= msg_d;
            mode_q     <= mode_d;
            roll_q     <= roll_d;
            out_data_q <= out_data_d;
            cnt_q      <= cnt_d;
            key_err_q  <= key_err_d;
        end
    end

    // Next-state and register update logic.
    always_comb begin
        state_d    = state_q;
        sess_key_d = sess_key_q;
        work_key_d = work_key_q;
        msg_d      = msg_q;
        mode_d     = mode_q;
        roll_d     = roll_q;
        out_data_d = out_data_q;
        cnt_d      = cnt_q;
        key_err_d  = 1'b0;

        case (state_q)
            ST_NOKEY: begin
                if (key_load) begin
                    sess_key_d = key_in;
                    work_key_d = key_in;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (in_valid) begin
                    // A byte handshake wins; a simultaneous key request is refused
                    // so the byte is processed with the key it arrived under.
                    msg_d     = in_data;
                    mode_d    = mode;
                    roll_d    = roll_en;
                    key_err_d = key_load | key_clear;
                    state_d   = ST_PROC;
                end else if (key_load) begin
                    sess_key_d = key_in;
                    work_key_d = key_in;
                    cnt_d      = '0;
                end else if (key_clear) begin
                    sess_key_d = '0;
                    work_key_d = '0;
                    state_d    = ST_NOKEY;
                end
            end
            ST_PROC: begin
                out_data_d = (mode_q == MODE_DEC) ? dec_result : enc_result;
                key_err_d  = key_load | key_clear;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                key_err_d = key_load | key_clear;
                if (out_ready) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (roll_q) begin
                        work_key_d = work_key_rot;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_NOKEY;
            end
        endcase
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_HOLD);
    assign key_valid  = (state_q != ST_NOKEY);
    assign dp_message = msg_q;
    assign dp_key     = work_key_q;
    assign out_data   = out_data_q;
    assign key_err    = key_err_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_crypt_stream_ctrl.sv
// Self-checking bench for crypt_stream_ctrl with a toy reversible datapath.
module tb_crypt_stream_ctrl;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset, key_load, key_clear, mode, roll_en;
    logic          in_valid, out_ready;
    logic [DW-1:0] key_in, in_data;
    logic          in_ready, out_valid, key_valid, key_err;
    logic [DW-1:0] dp_message, dp_key, enc_result, dec_result, out_data;
    logic [CW-1:0] byte_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] f_enc(input logic [7:0] m, input logic [7:0] k);
        return (m ^ k) + 8'h5A;
    endfunction
    function automatic logic [7:0] f_dec(input logic [7:0] c, input logic [7:0] k);
        return (c - 8'h5A) ^ k;
    endfunction
    function automatic logic [7:0] rotl1(input logic [7:0] k);
        return {k[6:0], k[7]};
    endfunction

    assign enc_result = f_enc(dp_message, dp_key);
    assign dec_result = f_dec(dp_message, dp_key);

    crypt_stream_ctrl #(.DATA_W(DW), .ROT(1), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .key_load(key_load), .key_in(key_in),
        .key_clear(key_clear), .mode(mode), .roll_en(roll_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dp_message(dp_message), .dp_key(dp_key),
        .enc_result(enc_result), .dec_result(dec_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_valid(key_valid), .key_err(key_err), .byte_count(byte_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a byte is "pending" from acceptance until the
    // downstream takes it; the result is the datapath function of the byte and key
    // in force when it was accepted.
    logic       m_live = 1'b0;
    logic       m_has_key = 1'b0;
    int         m_stage = 0;       // 0 free, 1 computing, 2 awaiting downstream
    logic [7:0] m_skey = 0, m_wkey = 0, m_msg = 0, m_res = 0, m_out = 0;
    logic       m_roll = 1'b0, m_err = 1'b0;
    logic [7:0] m_cnt = 0;

    always @(posedge clk) begin
        m_live = 1'b1;
        if (reset) begin
            m_has_key = 0; m_stage = 0; m_skey = 0; m_wkey = 0; m_msg = 0;
            m_res = 0; m_out = 0; m_roll = 0; m_err = 0; m_cnt = 0;
        end else begin
            m_err = 1'b0;
            if (!m_has_key) begin
                if (key_load) begin
                    m_has_key = 1; m_skey = key_in; m_wkey = key_in; m_cnt = 0;
                end
            end else if (m_stage == 0) begin
                if (in_valid) begin
                    m_msg  = in_data;
                    m_roll = roll_en;
                    m_res  = mode ? f_dec(in_data, m_wkey) : f_enc(in_data, m_wkey);
                    m_err  = key_load | key_clear;
                    m_stage = 1;
                end else if (key_load) begin
                    m_skey = key_in; m_wkey = key_in; m_cnt = 0;
                end else if (key_clear) begin
                    m_has_key = 0; m_skey = 0; m_wkey = 0;
                end
            end else if (m_stage == 1) begin
                m_err = key_load | key_clear;
                m_out = m_res;
                m_stage = 2;
            end else begin
                m_err = key_load | key_clear;
                if (out_ready) begin
                    m_cnt = m_cnt + 8'd1;
                    if (m_roll) m_wkey = rotl1(m_wkey);
                    m_stage = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready",   in_ready,   m_has_key && m_stage == 0);
            chk("out_valid",  out_valid,  m_has_key && m_stage == 2);
            chk("key_valid",  key_valid,  m_has_key);
            chk("key_err",    key_err,    m_err);
            chk("dp_key",     dp_key,     m_wkey);
            chk("dp_message", dp_message, m_msg);
            chk("out_data",   out_data,   m_out);
            chk("byte_count", byte_count, m_cnt);
        end
    end

    task automatic xfer(input logic [7:0] d, input logic md, input logic rl, input int hold,
                        output logic [7:0] res, output logic [7:0] kp);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("xfer_in_ready_wait", in_ready, 1);
        in_valid = 1; in_data = d; mode = md; roll_en = rl;
        @(negedge clk);
        in_valid = 0;
        kp = dp_key;
        @(negedge clk);
        chk("latency_out_valid", out_valid, 1);
        res = out_data;
        repeat (hold) @(negedge clk);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    logic [7:0] r, k;
    int errcnt;

    initial begin
        reset = 1; key_load = 0; key_clear = 0; key_in = 0; mode = 0; roll_en = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        reset = 0;

        // No key: input must be blocked
        in_valid = 1; in_data = 8'hAA;
        repeat (10) begin
            @(negedge clk);
            chk("nokey_in_ready", in_ready, 0);
            chk("nokey_out_valid", out_valid, 0);
            chk("nokey_key_valid", key_valid, 0);
        end
        in_valid = 0;

        // Load key and encrypt one byte
        key_load = 1; key_in = 8'h43;
        @(negedge clk);
        key_load = 0;
        chk("key_valid_after_load", key_valid, 1);
        in_valid = 1; in_data = 8'h55; mode = 0; roll_en = 0;
        @(negedge clk);
        in_valid = 0;
        chk("proc_dp_message", dp_message, 8'h55);
        chk("proc_dp_key", dp_key, 8'h43);
        chk("proc_out_valid", out_valid, 0);
        @(negedge clk);
        chk("enc_out_valid", out_valid, 1);
        chk("enc_out_data", out_data, 8'h70);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("count_one", byte_count, 1);

        // Round trip
        xfer(8'h70, 1'b1, 1'b0, 0, r, k);
        chk("dec_round_trip", r, 8'h55);

        // Rolling key
        key_load = 1; key_in = 8'h43;
        @(negedge clk);
        key_load = 0;
        xfer(8'h01, 0, 1, 0, r, k); chk("roll_key1", k, 8'h43);
        xfer(8'h02, 0, 1, 1, r, k); chk("roll_key2", k, 8'h86);
        xfer(8'h03, 0, 1, 2, r, k); chk("roll_key3", k, 8'h0D);

        // Backpressure with a rejected key_load
        in_valid = 1; in_data = 8'h3C; mode = 0; roll_en = 0;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_out_data", out_data, 8'h80);
        errcnt = 0;
        for (int i = 0; i < 5; i++) begin
            key_load = (i == 1); key_in = 8'hFF;
            @(negedge clk);
            key_load = 0;
            chk("hold_data_stable", out_data, 8'h80);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_dp_key", dp_key, 8'h1A);
            if (key_err) errcnt++;
        end
        chk("hold_key_err_pulses", errcnt, 1);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("hold_back_idle", in_ready, 1);

        // Reset during PROC
        in_valid = 1; in_data = 8'h11;
        @(negedge clk);
        in_valid = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dp_message", dp_message, 0);
        chk("rst_dp_key", dp_key, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_err", key_err, 0);
        chk("rst_byte_count", byte_count, 0);

        // Randomized traffic against the reference
        key_load = 1; key_in = 8'($urandom);
        @(negedge clk);
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            key_load  = ($urandom_range(0, 19) == 0);
            key_clear = ($urandom_range(0, 39) == 0);
            key_in    = 8'($urandom);
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            mode      = 1'($urandom);
            roll_en   = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
        end
        reset = 0; key_load = 0; key_clear = 0; in_valid = 0; out_ready = 0;

        // Counter wrap (counter is 8 bits in this build)
        reset = 1;
        @(negedge clk);
        reset = 0;
        key_load = 1; key_in = 8'h5C;
        @(negedge clk);
        key_load = 0;
        for (int b = 0; b < 255; b++) xfer(8'(b), 1'($urandom), 1'($urandom), 0, r, k);
        chk("count_max", byte_count, 8'hFF);
        xfer(8'h77, 0, 0, 0, r, k);
        chk("count_wrap", byte_count, 8'h00);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
